// File: rtl/fifo_pkg.sv
// Shared sizing constants for the programmable-threshold synchronous FIFO.
// Occupancy and threshold values need one bit more than the memory address.
package fifo_pkg;

   localparam int unsigned FIFO_WIDTH_DEF = 8;
   localparam int unsigned FIFO_DEPTH_DEF = 32;

   // Width of pointers, count and thresholds: address bits plus a wrap bit.
   function automatic int unsigned occ_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_ram.sv
// Single-clock simple dual-port storage: synchronous write, asynchronous read.
// Contents are intentionally never reset.
module fifo_ram #(
   parameter int unsigned width = 8,
   parameter int unsigned depth = 32,
   parameter int unsigned aw    = $clog2(depth)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [aw-1:0]    waddr,
   input  logic [width-1:0] wdata,
   input  logic [aw-1:0]    raddr,
   output logic [width-1:0] rdata
);

   logic [width-1:0] mem_q [depth];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and selectable registered or FWFT read.
module sync_fifo_prog
   import fifo_pkg::*;
#(
   parameter int unsigned fifo_width = FIFO_WIDTH_DEF,
   parameter int unsigned fifo_depth = FIFO_DEPTH_DEF,
   parameter int unsigned add_width  = $clog2(fifo_depth),
   parameter int unsigned fwft       = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  w_en,
   input  logic [fifo_width-1:0] w_data,
   input  logic                  r_en,
   output logic [fifo_width-1:0] r_data,
   output logic                  r_valid,
   input  logic [add_width:0]    af_thresh,
   input  logic [add_width:0]    ae_thresh,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [add_width:0]    count,
   input  logic                  err_clr,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int unsigned OCC_W = occ_width(fifo_depth);
   localparam logic [add_width:0] DEPTH_C = OCC_W'(fifo_depth);

   logic [add_width:0]    wr_ptr_q, wr_ptr_d;
   logic [add_width:0]    rd_ptr_q, rd_ptr_d;
   logic [add_width:0]    count_q, count_d;
   logic                  ovf_q, ovf_d;
   logic                  udf_q, udf_d;
   logic                  wr_acc, rd_acc;
   logic [fifo_width-1:0] ram_rdata;

   // Status flags decode the registered occupancy only.
   assign count        = count_q;
   assign full         = (count_q == DEPTH_C);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= af_thresh);
   assign almost_empty = (count_q <= ae_thresh);
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

   always_comb begin
      wr_acc   = w_en & ~full & ~flush;
      rd_acc   = r_en & ~empty & ~flush;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (wr_acc) wr_ptr_d = wr_ptr_q + OCC_W'(1);
         if (rd_acc) rd_ptr_d = rd_ptr_q + OCC_W'(1);
         case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + OCC_W'(1);
            2'b01:   count_d = count_q - OCC_W'(1);
            default: count_d = count_q;
         endcase
      end
      // A new error event wins over a same-cycle clear; flushed requests never flag.
      ovf_d = (w_en & full & ~flush) | (ovf_q & ~err_clr);
      udf_d = (r_en & empty & ~flush) | (udf_q & ~err_clr);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   fifo_ram #(
      .width (fifo_width),
      .depth (fifo_depth),
      .aw    (add_width)
   ) u_ram (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr_q[add_width-1:0]),
      .wdata (w_data),
      .raddr (rd_ptr_q[add_width-1:0]),
      .rdata (ram_rdata)
   );

   if (fwft == 0) begin : g_reg_read
      logic [fifo_width-1:0] r_data_q, r_data_d;
      logic                  r_valid_q, r_valid_d;

      // Registered read: the popped word is captured at the accepting edge.
      always_comb begin
         r_valid_d = rd_acc;
         r_data_d  = rd_acc ? ram_rdata : r_data_q;
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_data_q  <= '0;
            r_valid_q <= 1'b0;
         end else begin
            r_data_q  <= r_data_d;
            r_valid_q <= r_valid_d;
         end
      end

      assign r_data  = r_data_q;
      assign r_valid = r_valid_q;
   end else begin : g_fwft_read
      assign r_data  = ram_rdata;
      assign r_valid = ~empty;
   end

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: registered-read and FWFT instances share one
// stimulus stream and are compared every cycle against a queue model.
module tb_sync_fifo_prog;

   localparam int unsigned W  = 8;
   localparam int unsigned D  = 32;
   localparam int unsigned AW = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          flush = 1'b0;
   logic          w_en = 1'b0;
   logic [W-1:0]  w_data = '0;
   logic          r_en = 1'b0;
   logic          err_clr = 1'b0;
   logic [AW:0]   af_thresh = '0;
   logic [AW:0]   ae_thresh = 6'd3;

   logic [W-1:0]  c0_rd, c1_rd;
   logic          c0_rv, c1_rv;
   logic          c0_full, c0_empty, c0_af, c0_ae, c0_ov, c0_un;
   logic          c1_full, c1_empty, c1_af, c1_ae, c1_ov, c1_un;
   logic [AW:0]   c0_count, c1_count;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [W-1:0]  mq[$];
   bit            m_ov = 1'b0;
   bit            m_un = 1'b0;
   bit            m_rv = 1'b0;
   logic [W-1:0]  m_rd = '0;

   always #5 clk = ~clk;

   sync_fifo_prog #(.fifo_width(W), .fifo_depth(D), .fwft(0)) dut0 (
      .clk(clk), .rst(rst), .flush(flush), .w_en(w_en), .w_data(w_data),
      .r_en(r_en), .r_data(c0_rd), .r_valid(c0_rv),
      .af_thresh(af_thresh), .ae_thresh(ae_thresh),
      .full(c0_full), .empty(c0_empty), .almost_full(c0_af), .almost_empty(c0_ae),
      .count(c0_count), .err_clr(err_clr), .overflow(c0_ov), .underflow(c0_un)
   );

   sync_fifo_prog #(.fifo_width(W), .fifo_depth(D), .fwft(1)) dut1 (
      .clk(clk), .rst(rst), .flush(flush), .w_en(w_en), .w_data(w_data),
      .r_en(r_en), .r_data(c1_rd), .r_valid(c1_rv),
      .af_thresh(af_thresh), .ae_thresh(ae_thresh),
      .full(c1_full), .empty(c1_empty), .almost_full(c1_af), .almost_empty(c1_ae),
      .count(c1_count), .err_clr(err_clr), .overflow(c1_ov), .underflow(c1_un)
   );

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: a queue of accepted words plus sticky error bits.
   always @(posedge clk or posedge rst) begin : model
      int  n;
      bit  wa, ra;
      if (rst) begin
         mq.delete();
         m_ov = 1'b0;
         m_un = 1'b0;
         m_rv = 1'b0;
         m_rd = '0;
      end else begin
         n  = mq.size();
         wa = w_en && (n != D) && !flush;
         ra = r_en && (n != 0) && !flush;
         m_ov = (w_en && (n == D) && !flush) || (m_ov && !err_clr);
         m_un = (r_en && (n == 0) && !flush) || (m_un && !err_clr);
         if (flush) begin
            mq.delete();
            m_rv = 1'b0;
         end else begin
            m_rv = ra;
            if (ra) m_rd = mq.pop_front();
            if (wa) mq.push_back(w_data);
         end
      end
   end

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin : compare
      int n;
      n = mq.size();
      chk("count0", int'(c0_count), n);
      chk("count1", int'(c1_count), n);
      chk("full0", int'(c0_full), int'(n == D));
      chk("full1", int'(c1_full), int'(n == D));
      chk("empty0", int'(c0_empty), int'(n == 0));
      chk("empty1", int'(c1_empty), int'(n == 0));
      chk("afull0", int'(c0_af), int'(n >= int'(af_thresh)));
      chk("afull1", int'(c1_af), int'(n >= int'(af_thresh)));
      chk("aempty0", int'(c0_ae), int'(n <= int'(ae_thresh)));
      chk("aempty1", int'(c1_ae), int'(n <= int'(ae_thresh)));
      chk("ovf0", int'(c0_ov), int'(m_ov));
      chk("ovf1", int'(c1_ov), int'(m_ov));
      chk("udf0", int'(c0_un), int'(m_un));
      chk("udf1", int'(c1_un), int'(m_un));
      chk("rvalid0", int'(c0_rv), int'(m_rv));
      chk("rdata0", int'(c0_rd), int'(m_rd));
      chk("rvalid1", int'(c1_rv), int'(n != 0));
      if (n != 0) chk("rdata1", int'(c1_rd), int'(mq[0]));
   end

   // Apply one cycle of inputs; returns 2 time units after the edge.
   task automatic cyc(input bit w, input logic [W-1:0] d, input bit r,
                      input bit f, input bit e);
      w_en = w; w_data = d; r_en = r; flush = f; err_clr = e;
      @(posedge clk);
      #2;
      w_en = 1'b0; r_en = 1'b0; flush = 1'b0; err_clr = 1'b0;
   endtask

   initial begin
      // Reset values, including almost_full with a zero threshold
      repeat (2) @(posedge clk);
      #2;
      chk("rst_count", int'(c0_count), 0);
      chk("rst_empty", int'(c0_empty), 1);
      chk("rst_full", int'(c0_full), 0);
      chk("rst_ae", int'(c0_ae), 1);
      chk("rst_af_zero", int'(c0_af), 1);
      chk("rst_rvalid", int'(c0_rv), 0);
      chk("rst_rdata", int'(c0_rd), 0);
      af_thresh = 6'd28;
      #1;
      chk("rst_af_28", int'(c0_af), 0);
      @(posedge clk);
      #2;
      rst = 1'b0;

      // Test 1: fill, overflow, ordered drain
      for (int i = 1; i <= 32; i++) cyc(1'b1, W'(i), 1'b0, 1'b0, 1'b0);
      chk("t1_count", int'(c0_count), 32);
      chk("t1_full", int'(c0_full), 1);
      cyc(1'b1, 8'h21, 1'b0, 1'b0, 1'b0);
      chk("t1_ovf", int'(c0_ov), 1);
      chk("t1_count33", int'(c0_count), 32);
      for (int i = 1; i <= 32; i++) begin
         cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
         chk("t1_rvalid", int'(c0_rv), 1);
         chk("t1_rdata", int'(c0_rd), i);
      end
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk("t1_rvalid_drop", int'(c0_rv), 0);
      chk("t1_rdata_hold", int'(c0_rd), 32);

      // Test 2: almost_full at 28, then test 3 full simultaneous op
      cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
      chk("t2_ovf_clr", int'(c0_ov), 0);
      for (int i = 1; i <= 32; i++) begin
         cyc(1'b1, W'(8'h40 + i), 1'b0, 1'b0, 1'b0);
         if (i == 27) chk("t2_af_27", int'(c0_af), 0);
         if (i == 28) chk("t2_af_28", int'(c0_af), 1);
      end
      cyc(1'b1, 8'h99, 1'b1, 1'b0, 1'b0);
      chk("t3_full_count", int'(c0_count), 31);
      chk("t3_full_ovf", int'(c0_ov), 1);
      chk("t3_full_rdata", int'(c0_rd), 8'h41);
      for (int j = 1; j <= 31; j++) begin
         cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
         if (j == 27) chk("t2_ae_4", int'(c0_ae), 0);
         if (j == 28) chk("t2_ae_3", int'(c0_ae), 1);
      end
      cyc(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
      chk("t3_empty_count", int'(c0_count), 1);
      chk("t3_empty_udf", int'(c0_un), 1);
      chk("t3_empty_rvalid", int'(c0_rv), 0);

      // Test 4: flush with concurrent write
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b1);
      chk("t4_flush_count", int'(c0_count), 0);
      chk("t4_err_clr", int'(c0_un), 0);
      cyc(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 8'hDD, 1'b0, 1'b1, 1'b0);
      chk("t4_count", int'(c0_count), 0);
      chk("t4_empty", int'(c0_empty), 1);
      chk("t4_no_ovf", int'(c0_ov), 0);
      cyc(1'b1, 8'hCC, 1'b0, 1'b0, 1'b0);
      chk("t4_fwft_cc", int'(c1_rd), 8'hCC);
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("t4_rdata_cc", int'(c0_rd), 8'hCC);

      // Test 5: FWFT presents the head without a read request
      cyc(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
      chk("t5_rvalid", int'(c1_rv), 1);
      chk("t5_rdata", int'(c1_rd), 8'h5A);
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("t5_empty", int'(c1_empty), 1);
      chk("t5_rvalid_drop", int'(c1_rv), 0);
      cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
      chk("t5_udf", int'(c1_un), 1);

      // Test 6: asynchronous reset mid-burst at count 17
      for (int i = 0; i < 17; i++) cyc(1'b1, W'(8'h80 + i), 1'b0, 1'b0, 1'b0);
      chk("t6_count17", int'(c0_count), 17);
      w_en = 1'b1; w_data = 8'hEE; r_en = 1'b1;
      #1 rst = 1'b1;
      #1;
      chk("t6_count", int'(c0_count), 0);
      chk("t6_empty", int'(c0_empty), 1);
      chk("t6_full", int'(c0_full), 0);
      chk("t6_ae", int'(c0_ae), 1);
      chk("t6_af", int'(c0_af), 0);
      chk("t6_rvalid0", int'(c0_rv), 0);
      chk("t6_rvalid1", int'(c1_rv), 0);
      chk("t6_rdata", int'(c0_rd), 0);
      chk("t6_ovf", int'(c0_ov), 0);
      chk("t6_udf", int'(c1_un), 0);
      @(posedge clk);
      #2;
      rst = 1'b0; w_en = 1'b0; r_en = 1'b0;
      chk("t6_inflight_dropped", int'(c0_count), 0);

      // Randomized traffic in write-heavy, read-heavy and balanced phases
      for (int k = 0; k < 600; k++) begin
         int unsigned wp, rp;
         wp = (k < 150) ? 80 : (k < 300) ? 25 : 55;
         rp = (k < 150) ? 25 : (k < 300) ? 80 : 50;
         cyc(($urandom_range(99) < wp), W'($urandom),
             ($urandom_range(99) < rp),
             ($urandom_range(59) == 0), ($urandom_range(29) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sync_fifo_prog.md
SYNC_FIFO_PROG -- requirements
Module: sync_fifo_prog

Interface
REQ-001 Parameter fifo_width, default 8, data word width in bits; SHALL be >= 1.
REQ-002 Parameter fifo_depth, default 32, number of entries; SHALL be a power of 2 and >= 4.
REQ-003 Parameter add_width, default $clog2(fifo_depth), address width; derived, never overridden.
REQ-004 Parameter fwft, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-005 Decided: one clock, and reset is asynchronous and active-high.
REQ-006 clk  input  1  sole clock; all state changes on the rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 flush  input  1  synchronous clear of FIFO contents.
REQ-009 w_en  input  1  write request.
REQ-010 w_data  input  fifo_width  write data.
REQ-011 r_en  input  1  read request.
REQ-012 r_data  output  fifo_width  read data.
REQ-013 r_valid  output  1  r_data valid qualifier.
REQ-014 af_thresh  input  add_width+1  almost-full threshold, quasi-static.
REQ-015 ae_thresh  input  add_width+1  almost-empty threshold, quasi-static.
REQ-016 full, empty, almost_full, almost_empty  output  1 each  status flags.
REQ-017 count  output  add_width+1  current occupancy, range 0..fifo_depth.
REQ-018 err_clr  input  1  clears the sticky error flags.
REQ-019 overflow, underflow  output  1 each  sticky error flags.

Function
REQ-020 A write SHALL be accepted when w_en=1, full=0 and flush=0; full is evaluated from the current registered count, with no same-cycle read pass-through.
REQ-021 A read SHALL be accepted when r_en=1, empty=0 and flush=0.
REQ-022 Pointers SHALL be add_width+1 bits, increment by 1 per accepted operation, and wrap modulo 2*fifo_depth; the low add_width bits address the memory.
REQ-023 count SHALL update as follows: +1 on a write only, -1 on a read only, unchanged when both or neither are accepted.
REQ-024 Flags SHALL be combinational from the registered count, so they change in the cycle after the accepted operation: full = (count==fifo_depth); empty = (count==0); almost_full = (count>=af_thresh); almost_empty = (count<=ae_thresh).
REQ-025 When simultaneous read and write occur while full, the read SHALL be accepted, the write rejected, and overflow set.
REQ-026 When simultaneous read and write occur while empty, the write SHALL be accepted, the read rejected, and underflow set.
REQ-027 overflow SHALL set on w_en=1 with full=1; underflow SHALL set on r_en=1 with empty=1; both SHALL remain set until err_clr or rst, with set taking priority over err_clr in the same cycle.
REQ-028 flush SHALL zero both pointers and count at the next edge and drop any same-cycle w_en or r_en without flagging them; in fwft=0 it SHALL also clear r_valid; sticky flags SHALL be unaffected.
REQ-029 With fwft=0, an accepted read SHALL load r_data at that edge and assert r_valid for exactly the following cycle; otherwise r_data SHALL hold its value and r_valid SHALL be 0.
REQ-030 With fwft=1, r_data SHALL show the head entry combinationally, r_valid SHALL equal !empty, and an accepted read SHALL pop the head.
REQ-031 Writes SHALL land in memory at the accepting edge and be readable no earlier than the next cycle.

Reset
REQ-032 While rst=1: pointers = 0, count = 0, empty = 1, full = 0, almost_empty = 1, almost_full = (af_thresh==0), r_valid = 0, r_data = 0 (fwft=0), overflow = 0, underflow = 0.
REQ-033 Memory contents SHALL NOT be reset or preloaded.
REQ-034 Assertion of rst mid-operation SHALL discard all stored data immediately; data in flight at the next edge SHALL be discarded.

Structure
REQ-035 Shared package fifo_pkg SHALL hold the default width and depth constants and the occupancy/threshold width rule (add_width+1).
REQ-036 Storage SHALL be a sub-module fifo_ram: a single-clock simple dual-port array with synchronous write and asynchronous read; all control logic stays in sync_fifo_prog.

Verification
REQ-037 Test 1 (defaults, fwft=0): write 0x01..0x20 -> full=1 and count=32; a 33rd write -> overflow=1 with contents unchanged; 32 reads -> 0x01..0x20 in order, each r_valid one cycle after its r_en.
REQ-038 Test 2: af_thresh=28, ae_thresh=3; fill one word at a time -> almost_full rises the cycle after count reaches 28; drain -> almost_empty rises the cycle after count reaches 3.
REQ-039 Test 3: at count=32 assert w_en and r_en together -> count=31, overflow=1; at count=0 assert both -> count=1, underflow=1.
REQ-040 Test 4: write 0xAA,0xBB, then flush together with w_en -> count=0, empty=1, no overflow; the following write of 0xCC reads back as 0xCC.
REQ-041 Test 5 (fwft=1): write 0x5A to an empty FIFO -> the next cycle r_valid=1 and r_data=0x5A with no r_en; r_en -> empty=1 in the next cycle.
REQ-042 Test 6: assert rst asynchronously mid-burst at count=17 -> all outputs at the REQ-032 values before the next clk edge; sustained wrap over 3*fifo_depth accesses passes a scoreboard check.
